// File: rtl/greenflow_pkg.sv
// Shared GreenFlow definitions: gate status codes, ramp FSM encodings and the
// fail-safe power level.
package greenflow_pkg;

  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_GRID_CLIP = 2'b01;
  localparam logic [1:0] ST_TEMP_TRIP = 2'b10;
  localparam logic [1:0] ST_AI_FAULT  = 2'b11;

  localparam logic [15:0] FAILSAFE_POWER = 16'd0;

  typedef enum logic [1:0] {
    RampIdle    = 2'b00,
    RampRun     = 2'b01,
    RampTrip    = 2'b10,
    RampHoldoff = 2'b11
  } ramp_state_e;

endpackage

// File: rtl/greenflow_ramp_ctrl_if.sv
// Gate-to-charger link: enforced power/status in, driven setpoint and telemetry out.
interface greenflow_ramp_ctrl_if;

  logic [15:0] target_kw;
  logic [1:0]  status_code;
  logic        enable;
  logic [15:0] charger_setpoint_kw;
  logic [1:0]  ramp_state;
  logic        at_target;
  logic [7:0]  trip_count;

  modport master (
    output target_kw, status_code, enable,
    input  charger_setpoint_kw, ramp_state, at_target, trip_count
  );

  modport slave (
    input  target_kw, status_code, enable,
    output charger_setpoint_kw, ramp_state, at_target, trip_count
  );

endinterface

// File: rtl/greenflow_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks.
module greenflow_tick_gen #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned   CntW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  assign tick = (cnt_q == CntMax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/greenflow_ramp_ctrl.sv
// Charger setpoint controller: slew-limited ramp-up, immediate cuts, post-fault
// restart hold-off and saturating trip counter.
module greenflow_ramp_ctrl
  import greenflow_pkg::*;
#(
  parameter logic [15:0] STEP_UP_KW    = 16'd5,
  parameter int unsigned TICK_DIV      = 1000,
  parameter int unsigned HOLDOFF_TICKS = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  greenflow_ramp_ctrl_if.slave bus
);

  localparam int unsigned      HoldW    = (HOLDOFF_TICKS > 0) ? $clog2(HOLDOFF_TICKS + 1) : 1;
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLDOFF_TICKS);

  ramp_state_e      state_q;
  logic [15:0]      setpoint_q;
  logic             at_target_q;
  logic [7:0]       trip_q;
  logic [HoldW-1:0] hold_q;

  logic        tick;
  logic        fault;
  logic [7:0]  trip_inc;
  logic [16:0] headroom;
  logic [15:0] step_kw;
  logic [16:0] ramp_sum;

  greenflow_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Widened to 17 bits so the step never wraps or lands above target.
  always_comb begin
    fault    = (bus.status_code == ST_TEMP_TRIP) || (bus.status_code == ST_AI_FAULT);
    trip_inc = (trip_q == 8'hFF) ? trip_q : trip_q + 8'd1;
    headroom = {1'b0, bus.target_kw} - {1'b0, setpoint_q};
    step_kw  = (headroom > {1'b0, STEP_UP_KW}) ? STEP_UP_KW : headroom[15:0];
    ramp_sum = {1'b0, setpoint_q} + {1'b0, step_kw};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RampIdle;
      setpoint_q  <= FAILSAFE_POWER;
      at_target_q <= 1'b0;
      trip_q      <= '0;
      hold_q      <= '0;
    end else begin
      unique case (state_q)
        RampIdle: begin
          setpoint_q  <= FAILSAFE_POWER;
          at_target_q <= 1'b0;
          if (fault) begin
            state_q <= RampTrip;
            trip_q  <= trip_inc;
          end else if (bus.enable && (bus.target_kw != 16'd0)) begin
            state_q <= RampRun;
          end
        end
        RampRun: begin
          if (fault) begin
            state_q     <= RampTrip;
            setpoint_q  <= FAILSAFE_POWER;
            at_target_q <= 1'b0;
            trip_q      <= trip_inc;
          end else if (!bus.enable) begin
            state_q     <= RampIdle;
            setpoint_q  <= FAILSAFE_POWER;
            at_target_q <= 1'b0;
          end else if (bus.target_kw < setpoint_q) begin
            setpoint_q  <= bus.target_kw;
            at_target_q <= 1'b1;
          end else if (tick && (setpoint_q < bus.target_kw)) begin
            setpoint_q  <= ramp_sum[15:0];
            at_target_q <= (ramp_sum == {1'b0, bus.target_kw});
          end else begin
            at_target_q <= (setpoint_q == bus.target_kw);
          end
        end
        RampTrip: begin
          setpoint_q  <= FAILSAFE_POWER;
          at_target_q <= 1'b0;
          if (!fault) begin
            state_q <= RampHoldoff;
            hold_q  <= HoldLoad;
          end
        end
        RampHoldoff: begin
          setpoint_q  <= FAILSAFE_POWER;
          at_target_q <= 1'b0;
          if (fault) begin
            state_q <= RampTrip;
            trip_q  <= trip_inc;
          end else if (hold_q == '0) begin
            state_q <= RampIdle;
          end else if (tick) begin
            hold_q <= hold_q - HoldW'(1);
          end
        end
        default: state_q <= RampIdle;
      endcase
    end
  end

  assign bus.charger_setpoint_kw = setpoint_q;
  assign bus.ramp_state          = state_q;
  assign bus.at_target           = at_target_q;
  assign bus.trip_count          = trip_q;

endmodule
